// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the pipe_chain register pipeline.
package pipe_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 4;
    localparam int DEF_CNT_W = 16;
    localparam int MAX_DEPTH = 16;

    // Number of set bits in a stage-sized vector (result 0..16 fits in 5 bits).
    function automatic logic [4:0] popcount(input logic [MAX_DEPTH-1:0] vec);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < MAX_DEPTH; i++) begin
            n = n + {4'b0000, vec[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating event counter with synchronous clear and a multi-bit increment.
module pipe_sat_counter #(
    parameter int CNT_W = 16,
    parameter int INC_W = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [INC_W-1:0] inc,
    output logic [CNT_W-1:0] count
);

    // One spare bit above the wider operand so a carry out is never lost.
    localparam int SUM_W = ((CNT_W > INC_W) ? CNT_W : INC_W) + 1;
    localparam logic [SUM_W-1:0] MAX_VAL = {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [SUM_W-1:0] sum;

    // Next count: clear wins, otherwise add and clamp at all-ones.
    always_comb begin
        sum     = SUM_W'(count_q) + SUM_W'(inc);
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (sum > MAX_VAL) begin
            count_d = '1;
        end else begin
            count_d = sum[CNT_W-1:0];
        end
    end

    // Counter register, wiped immediately by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_chain.sv
// Linear register pipeline with per-stage stall/flush and statistics counters.
module pipe_chain
    import pipe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = DEF_CNT_W,
    parameter int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   in_ready,
    input  logic [DEPTH-1:0]       stall,
    input  logic [DEPTH-1:0]       flush,
    input  logic                   clr_cnt,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    output logic [DEPTH-1:0]       stage_valid,
    output logic [DEPTH*WIDTH-1:0] stage_data,
    output logic [OCC_W-1:0]       occupancy,
    output logic [CNT_W-1:0]       stall_cycles,
    output logic [CNT_W-1:0]       bubble_cnt,
    output logic [CNT_W-1:0]       flush_cnt
);

    logic [DEPTH-1:0] hold;
    logic [DEPTH-1:0] valid_vec;
    logic [WIDTH-1:0] data_arr [DEPTH];
    logic             bubble;
    logic [OCC_W-1:0] flush_kill;

    // A stall freezes its own stage and everything upstream of it.
    always_comb begin
        hold = '0;
        hold[DEPTH-1] = stall[DEPTH-1];
        for (int i = DEPTH - 2; i >= 0; i--) begin
            hold[i] = stall[i] | hold[i+1];
        end
    end

    genvar g;
    for (g = 0; g < DEPTH; g++) begin : g_stage
        logic             up_valid;
        logic [WIDTH-1:0] up_data;
        logic             v_q;
        logic             v_d;
        logic [WIDTH-1:0] d_q;
        logic [WIDTH-1:0] d_d;

        if (g == 0) begin : g_src_in
            assign up_valid = in_valid;
            assign up_data  = in_data;
        end else begin : g_src_prev
            // A stalled or flushed upstream stage hands down a bubble.
            assign up_valid = valid_vec[g-1] & ~flush[g-1] & ~stall[g-1];
            assign up_data  = data_arr[g-1];
        end

        // Stage next state: flush beats hold, hold beats load.
        always_comb begin
            v_d = up_valid;
            d_d = up_data;
            if (flush[g]) begin
                v_d = 1'b0;
                d_d = d_q;
            end else if (hold[g]) begin
                v_d = v_q;
                d_d = d_q;
            end
        end

        // Stage register; reset discards both the valid bit and the payload.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                d_q <= '0;
            end else begin
                v_q <= v_d;
                d_q <= d_d;
            end
        end

        assign valid_vec[g]                  = v_q;
        assign data_arr[g]                   = d_q;
        assign stage_data[g*WIDTH +: WIDTH]  = d_q;
    end

    // A bubble is born wherever a stalled stage feeds a stage that keeps moving.
    always_comb begin
        bubble = 1'b0;
        for (int i = 1; i < DEPTH; i++) begin
            if (stall[i-1] && !hold[i]) begin
                bubble = 1'b1;
            end
        end
    end

    assign flush_kill  = OCC_W'(popcount(MAX_DEPTH'(flush & valid_vec)));
    assign occupancy   = OCC_W'(popcount(MAX_DEPTH'(valid_vec)));
    assign stage_valid = valid_vec;
    assign in_ready    = ~hold[0];
    assign out_valid   = valid_vec[DEPTH-1] & ~stall[DEPTH-1] & ~flush[DEPTH-1];
    assign out_data    = data_arr[DEPTH-1];

    pipe_sat_counter #(.CNT_W(CNT_W), .INC_W(1)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_cnt),
        .inc   (|stall),
        .count (stall_cycles)
    );

    pipe_sat_counter #(.CNT_W(CNT_W), .INC_W(1)) u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_cnt),
        .inc   (bubble),
        .count (bubble_cnt)
    );

    pipe_sat_counter #(.CNT_W(CNT_W), .INC_W(OCC_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_cnt),
        .inc   (flush_kill),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_chain.sv
// Directed bench for pipe_chain: streaming table plus stall/flush/reset/saturation sequences.
module tb_pipe_chain;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_data;
    logic [3:0]  stall;
    logic [3:0]  flush;
    logic        clr_cnt;

    logic        in_ready, out_valid;
    logic [15:0] out_data;
    logic [3:0]  stage_valid;
    logic [63:0] stage_data;
    logic [2:0]  occupancy;
    logic [15:0] stall_cycles, bubble_cnt, flush_cnt;

    logic        s_in_ready, s_out_valid;
    logic [15:0] s_out_data;
    logic [3:0]  s_stage_valid;
    logic [63:0] s_stage_data;
    logic [2:0]  s_occupancy;
    logic [3:0]  s_stall_cycles, s_bubble_cnt, s_flush_cnt;

    int total = 0;
    int bad   = 0;

    localparam logic [15:0] D0 = 16'h1111;
    localparam logic [15:0] D1 = 16'h2222;
    localparam logic [15:0] D2 = 16'h3333;
    localparam logic [15:0] D3 = 16'h4444;

    typedef struct {
        logic        iv;
        logic [15:0] data;
        logic        exp_ov;
        logic [15:0] exp_od;
        logic        exp_ir;
        logic [3:0]  exp_sv;
        logic [2:0]  exp_occ;
    } vec_t;

    vec_t tbl [10];

    pipe_chain #(.WIDTH(16), .DEPTH(4), .CNT_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .stall        (stall),
        .flush        (flush),
        .clr_cnt      (clr_cnt),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .stage_valid  (stage_valid),
        .stage_data   (stage_data),
        .occupancy    (occupancy),
        .stall_cycles (stall_cycles),
        .bubble_cnt   (bubble_cnt),
        .flush_cnt    (flush_cnt)
    );

    pipe_chain #(.WIDTH(16), .DEPTH(4), .CNT_W(4)) dut_small (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (s_in_ready),
        .stall        (stall),
        .flush        (flush),
        .clr_cnt      (clr_cnt),
        .out_valid    (s_out_valid),
        .out_data     (s_out_data),
        .stage_valid  (s_stage_valid),
        .stage_data   (s_stage_data),
        .occupancy    (s_occupancy),
        .stall_cycles (s_stall_cycles),
        .bubble_cnt   (s_bubble_cnt),
        .flush_cnt    (s_flush_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive all inputs, then let combinational outputs settle.
    task automatic apply_stimulus(input logic iv, input logic [15:0] d, input logic [3:0] st,
                                  input logic [3:0] fl, input logic clr);
        in_valid = iv;
        in_data  = d;
        stall    = st;
        flush    = fl;
        clr_cnt  = clr;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse placed strictly between clock edges.
    task automatic do_reset();
        apply_stimulus(1'b0, 16'h0, 4'b0, 4'b0, 1'b0);
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        step();
    endtask

    task automatic fill_pipe();
        do_reset();
        apply_stimulus(1'b1, D0, 4'b0, 4'b0, 1'b0); step();
        apply_stimulus(1'b1, D1, 4'b0, 4'b0, 1'b0); step();
        apply_stimulus(1'b1, D2, 4'b0, 4'b0, 1'b0); step();
        apply_stimulus(1'b1, D3, 4'b0, 4'b0, 1'b0); step();
        apply_stimulus(1'b0, 16'h0, 4'b0, 4'b0, 1'b0);
    endtask

    initial begin
        tbl[0] = '{1'b1, 16'h0001, 1'b0, 16'h0000, 1'b1, 4'b0001, 3'd1};
        tbl[1] = '{1'b1, 16'h0002, 1'b0, 16'h0000, 1'b1, 4'b0011, 3'd2};
        tbl[2] = '{1'b1, 16'h0003, 1'b0, 16'h0000, 1'b1, 4'b0111, 3'd3};
        tbl[3] = '{1'b1, 16'h0004, 1'b0, 16'h0000, 1'b1, 4'b1111, 3'd4};
        tbl[4] = '{1'b1, 16'h0005, 1'b1, 16'h0001, 1'b1, 4'b1111, 3'd4};
        tbl[5] = '{1'b1, 16'h0006, 1'b1, 16'h0002, 1'b1, 4'b1111, 3'd4};
        tbl[6] = '{1'b1, 16'h0007, 1'b1, 16'h0003, 1'b1, 4'b1111, 3'd4};
        tbl[7] = '{1'b1, 16'h0008, 1'b1, 16'h0004, 1'b1, 4'b1111, 3'd4};
        tbl[8] = '{1'b0, 16'h0000, 1'b1, 16'h0005, 1'b1, 4'b1110, 3'd3};
        tbl[9] = '{1'b0, 16'h0000, 1'b1, 16'h0006, 1'b1, 4'b1100, 3'd2};

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        stall    = '0;
        flush    = '0;
        clr_cnt  = 1'b0;
        #2;
        check_output("reset_sv",        32'(stage_valid), 32'h0);
        check_output("reset_occ",       32'(occupancy), 32'h0);
        check_output("reset_out_valid", 32'(out_valid), 32'h0);
        check_output("reset_in_ready",  32'(in_ready), 32'h1);
        check_output("reset_stall_cnt", 32'(stall_cycles), 32'h0);
        #8 rst_n = 1'b1;
        step();

        // Streaming with no stalls.
        for (int k = 0; k < 10; k++) begin
            apply_stimulus(tbl[k].iv, tbl[k].data, 4'b0, 4'b0, 1'b0);
            check_output($sformatf("stream%0d_out_valid", k), 32'(out_valid), 32'(tbl[k].exp_ov));
            if (tbl[k].exp_ov)
                check_output($sformatf("stream%0d_out_data", k), 32'(out_data), 32'(tbl[k].exp_od));
            check_output($sformatf("stream%0d_in_ready", k), 32'(in_ready), 32'(tbl[k].exp_ir));
            step();
            check_output($sformatf("stream%0d_sv", k), 32'(stage_valid), 32'(tbl[k].exp_sv));
            check_output($sformatf("stream%0d_occ", k), 32'(occupancy), 32'(tbl[k].exp_occ));
        end

        // Stall at stage 2 for two cycles on a full pipe.
        fill_pipe();
        check_output("fill_sv", 32'(stage_valid), 32'hF);
        apply_stimulus(1'b1, 16'h00AA, 4'b0100, 4'b0, 1'b0);
        check_output("stall_in_ready", 32'(in_ready), 32'h0);
        check_output("stall_c1_out_valid", 32'(out_valid), 32'h1);
        check_output("stall_c1_out_data", 32'(out_data), 32'(D0));
        step();
        check_output("stall_c1_sv", 32'(stage_valid), 32'h7);
        check_output("stall_c2_out_valid", 32'(out_valid), 32'h0);
        step();
        check_output("stall_c2_sv", 32'(stage_valid), 32'h7);
        check_output("stall_hold_s0", 32'(stage_data[15:0]), 32'(D3));
        check_output("stall_cycles", 32'(stall_cycles), 32'd2);
        check_output("stall_bubbles", 32'(bubble_cnt), 32'd2);
        apply_stimulus(1'b0, 16'h0, 4'b0, 4'b0, 1'b0);
        step();
        check_output("stall_rel_sv", 32'(stage_valid), 32'hE);
        check_output("stall_rel_out_data", 32'(out_data), 32'(D1));
        check_output("stall_rel_out_valid", 32'(out_valid), 32'h1);

        // Flush stages 0 and 1 on a full pipe; their words must never retire.
        fill_pipe();
        apply_stimulus(1'b1, 16'h00BB, 4'b0, 4'b0011, 1'b0);
        check_output("flush_out_data", 32'(out_data), 32'(D0));
        step();
        check_output("flush_sv", 32'(stage_valid), 32'h8);
        check_output("flush_cnt", 32'(flush_cnt), 32'd2);
        apply_stimulus(1'b0, 16'h0, 4'b0, 4'b0, 1'b0);
        check_output("flush_next_out", 32'(out_data), 32'(D1));
        for (int k = 0; k < 3; k++) begin
            step();
            check_output($sformatf("flush_drain%0d_out_valid", k), 32'(out_valid), 32'h0);
        end

        // Stall and flush of stage 1 together.
        fill_pipe();
        apply_stimulus(1'b1, 16'h00CC, 4'b0010, 4'b0010, 1'b0);
        check_output("sf_in_ready", 32'(in_ready), 32'h0);
        step();
        check_output("sf_sv", 32'(stage_valid), 32'h9);
        check_output("sf_s0_data", 32'(stage_data[15:0]), 32'(D3));
        check_output("sf_out_data", 32'(out_data), 32'(D1));
        check_output("sf_bubble", 32'(bubble_cnt), 32'd1);
        check_output("sf_flush", 32'(flush_cnt), 32'd1);

        // Saturation on the 4-bit counter build, then clear against an increment.
        do_reset();
        apply_stimulus(1'b0, 16'h0, 4'b1111, 4'b0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            step();
            if (k == 13) check_output("sat_mid", 32'(s_stall_cycles), 32'hE);
        end
        check_output("sat_small", 32'(s_stall_cycles), 32'hF);
        check_output("sat_big", 32'(stall_cycles), 32'd20);
        check_output("sat_no_bubble", 32'(s_bubble_cnt), 32'h0);
        apply_stimulus(1'b0, 16'h0, 4'b1111, 4'b0, 1'b1);
        step();
        check_output("clr_small", 32'(s_stall_cycles), 32'h0);
        check_output("clr_big", 32'(stall_cycles), 32'h0);

        // Asynchronous reset mid-operation.
        fill_pipe();
        apply_stimulus(1'b0, 16'h0, 4'b0001, 4'b0, 1'b0);
        step();
        apply_stimulus(1'b0, 16'h0, 4'b0, 4'b0, 1'b0);
        check_output("pre_rst_stall_cnt", 32'(stall_cycles), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check_output("arst_sv", 32'(stage_valid), 32'h0);
        check_output("arst_occ", 32'(occupancy), 32'h0);
        check_output("arst_cnt", 32'(stall_cycles), 32'h0);
        check_output("arst_data", 32'(stage_data[31:0]), 32'h0);
        check_output("arst_out_valid", 32'(out_valid), 32'h0);
        apply_stimulus(1'b0, 16'h0, 4'b0100, 4'b0, 1'b0);
        check_output("arst_in_ready_held", 32'(in_ready), 32'h0);
        apply_stimulus(1'b1, 16'hCAFE, 4'b0, 4'b0, 1'b0);
        rst_n = 1'b1;
        step();
        check_output("post_rst_capture", 32'(stage_valid), 32'h1);
        apply_stimulus(1'b0, 16'h0, 4'b0, 4'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            check_output($sformatf("post_rst_wait%0d", k), 32'(out_valid), 32'h0);
            step();
        end
        check_output("post_rst_out_valid", 32'(out_valid), 32'h1);
        check_output("post_rst_out_data", 32'(out_data), 32'hCAFE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
